// File: rtl/inst_stage_queue.sv
// Instruction queue between fetch and decode. It holds DEPTH words, presents the head from a
// register, and retires call forms in two stages (push-PC pre-stage, then normal).
module inst_stage_queue #(
    parameter int          DEPTH     = 4,
    parameter int          INST_BITS = 16,
    parameter logic [3:0]  CC_CALL   = 4'hF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [INST_BITS-1:0]       in_inst,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [INST_BITS-1:0]       out_inst,
    output logic                       out_pre_stage,
    input  logic                       sc_inst_done,
    output logic                       inst_done,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [INST_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [LW-1:0]        level_reg, level_next;
    logic                 stage_reg;
    logic [INST_BITS-1:0] head_reg, head_next;
    logic                 need_pre, push, pop;

    assign need_pre = ((head_reg[15:12] == 4'b0000) && (head_reg[11:8] == CC_CALL)) ||
                      (head_reg[15:6] == 10'b0010000001);

    assign in_ready      = (level_reg < LW'(DEPTH)) && !flush;
    assign out_valid     = (level_reg != '0);
    assign out_pre_stage = out_valid && need_pre && !stage_reg;
    assign inst_done     = out_valid && !out_pre_stage && sc_inst_done && !flush;
    assign out_inst      = head_reg;
    assign level         = level_reg;

    assign push = in_valid && in_ready;
    assign pop  = inst_done;

    always_comb begin
        level_next  = level_reg;
        rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level_reg + LW'(1);
        end else if (!push && pop) begin
            level_next = level_reg - LW'(1);
        end
        // When the new head is the word being written right now, take it from the input.
        if (push && (rd_ptr_next == wr_ptr_reg)) begin
            head_next = in_inst;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_inst;
        end
        head_reg <= head_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            stage_reg  <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            level_reg  <= '0;
            stage_reg  <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (inst_done) begin
                stage_reg <= 1'b0;
            end else if (out_valid && sc_inst_done) begin
                stage_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_stage_queue.sv
// Bench for inst_stage_queue: a fixed vector table, hand sequences for the full/flush/streaming
// cases, then random traffic compared against a queue-based model.
module tb_inst_stage_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, sc_inst_done;
    logic [15:0] in_inst;
    logic        in_ready, out_valid, out_pre_stage, inst_done;
    logic [15:0] out_inst;
    logic [2:0]  level;

    inst_stage_queue #(.DEPTH(DEPTH), .INST_BITS(16), .CC_CALL(4'hF)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_inst(out_inst), .out_pre_stage(out_pre_stage),
        .sc_inst_done(sc_inst_done), .inst_done(inst_done), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] inst;
        logic        fl;
        logic        sc;
        logic        e_valid;
        logic [15:0] e_inst;
        logic        e_pre;
        logic        e_ready;
        logic        e_done;
        logic [2:0]  e_level;
    } vec_t;

    vec_t        tbl [11];
    int          total = 0;
    int          passed = 0;
    int          proto_errs = 0;

    logic [15:0] q [$];
    logic        pre_done = 1'b0;

    logic        a_valid, a_pre, a_ready, a_done;
    logic [15:0] a_inst;
    logic [2:0]  a_level;
    logic        e_valid, e_pre, e_ready, e_done;
    logic [15:0] e_inst;
    int          e_level;

    function automatic logic need_pre_f(input logic [15:0] w);
        return (w[15:12] == 4'h0 && w[11:8] == 4'hF) || (w[15:6] == 10'b0010000001);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Drive one cycle, sample outputs before the edge, then advance the reference model.
    task automatic cycle(input logic iv, input logic [15:0] w, input logic fl,
                         input logic sc, input logic rs);
        @(negedge clk);
        in_valid = iv; in_inst = w; flush = fl; sc_inst_done = sc; reset = rs;
        #2;
        a_valid = out_valid; a_inst = out_inst; a_pre = out_pre_stage;
        a_ready = in_ready; a_done = inst_done; a_level = level;

        e_valid = (q.size() != 0);
        e_inst  = 16'h0;
        e_pre   = 1'b0;
        if (e_valid) begin
            e_inst = q[0];
            e_pre  = need_pre_f(q[0]) && !pre_done;
        end
        e_ready = (q.size() < DEPTH) && !fl;
        e_done  = e_valid && !e_pre && sc && !fl;
        e_level = q.size();
        if (sc && !e_valid) proto_errs++;

        if (rs || fl) begin
            q.delete();
            pre_done = 1'b0;
        end else begin
            if (e_done) begin
                void'(q.pop_front());
                pre_done = 1'b0;
            end else if (e_valid && sc) begin
                pre_done = 1'b1;
            end
            if (iv && e_ready) q.push_back(w);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".out_valid"}, 32'(a_valid), 32'(e_valid));
        if (e_valid) chk({tag, ".out_inst"}, 32'(a_inst), 32'(e_inst));
        chk({tag, ".out_pre_stage"}, 32'(a_pre), 32'(e_pre));
        chk({tag, ".in_ready"}, 32'(a_ready), 32'(e_ready));
        chk({tag, ".inst_done"}, 32'(a_done), 32'(e_done));
        chk({tag, ".level"}, 32'(a_level), 32'(e_level));
    endtask

    initial begin
        //           iv    inst      fl    sc     valid e_inst    pre   ready done  level
        tbl[0]  = '{1'b1, 16'h8123, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h8123, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[2]  = '{1'b1, 16'h2041, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h2041, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h2041, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[5]  = '{1'b1, 16'h0F10, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 16'h0E10, 1'b0, 1'b1,  1'b1, 16'h0F10, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h0F10, 1'b0, 1'b1, 1'b1, 3'd2};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b1, 16'h0E10, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0};

        reset = 1'b1; in_valid = 1'b0; in_inst = 16'h0; flush = 1'b0; sc_inst_done = 1'b0;
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Reset state
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("reset.level", 32'(a_level), 32'd0);
        chk("reset.in_ready", 32'(a_ready), 32'd1);
        chk("reset.out_valid", 32'(a_valid), 32'd0);
        chk("reset.out_pre_stage", 32'(a_pre), 32'd0);
        chk("reset.inst_done", 32'(a_done), 32'd0);

        // Table: single push/retire, call src, branch call, non-call, empty retire
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].iv, tbl[i].inst, tbl[i].fl, tbl[i].sc, 1'b0);
            chk($sformatf("tbl%0d.out_valid", i), 32'(a_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d.out_inst", i), 32'(a_inst), 32'(tbl[i].e_inst));
            chk($sformatf("tbl%0d.out_pre_stage", i), 32'(a_pre), 32'(tbl[i].e_pre));
            chk($sformatf("tbl%0d.in_ready", i), 32'(a_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.inst_done", i), 32'(a_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.level", i), 32'(a_level), 32'(tbl[i].e_level));
        end

        // Fill to full, retire with in_valid held, then drain across the pointer wrap
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 16'h8000 + 16'(i), 1'b0, 1'b0, 1'b0);
            cmp_model("fill");
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cmp_model("full");
        chk("full.level", 32'(a_level), 32'd4);
        chk("full.in_ready", 32'(a_ready), 32'd0);
        cycle(1'b1, 16'h8004, 1'b0, 1'b1, 1'b0);
        cmp_model("full_retire");
        chk("full_retire.in_ready", 32'(a_ready), 32'd0);
        cycle(1'b1, 16'h8004, 1'b0, 1'b0, 1'b0);
        cmp_model("after_retire");
        chk("after_retire.in_ready", 32'(a_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            cmp_model("drain");
        end

        // Flush with level 3, head in pre-stage, and a word offered in the flush cycle
        cycle(1'b1, 16'h2041, 1'b0, 1'b0, 1'b0); cmp_model("pre_fill");
        cycle(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0); cmp_model("pre_fill");
        cycle(1'b1, 16'h8002, 1'b0, 1'b0, 1'b0); cmp_model("pre_fill");
        cycle(1'b1, 16'h8003, 1'b1, 1'b1, 1'b0);
        cmp_model("flush");
        chk("flush.level_before", 32'(a_level), 32'd3);
        chk("flush.pre_before", 32'(a_pre), 32'd1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cmp_model("post_flush");
        chk("post_flush.level", 32'(a_level), 32'd0);
        chk("post_flush.out_valid", 32'(a_valid), 32'd0);

        // Streaming: accept and retire each cycle holds level at 1
        cycle(1'b1, 16'h8100, 1'b0, 1'b0, 1'b0); cmp_model("stream");
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 16'h8100 + 16'(i), 1'b0, 1'b1, 1'b0);
            cmp_model("stream");
            chk("stream.level", 32'(a_level), 32'd1);
            chk("stream.inst_done", 32'(a_done), 32'd1);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0); cmp_model("stream_last");
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0); cmp_model("empty_sc");
        chk("empty_sc.inst_done", 32'(a_done), 32'd0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0); cmp_model("empty_after");
        chk("empty_after.level", 32'(a_level), 32'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            case ($urandom_range(0, 3))
                0: w = {4'h0, 4'hF, 8'($urandom)};
                1: w = {10'b0010000001, 6'($urandom)};
                default: w = 16'($urandom);
            endcase
            cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
            cmp_model("rand");
        end

        $display("protocol notes: %0d sc_inst_done pulses seen with an empty queue", proto_errs);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
